// File: rtl/rx_frame_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// rx_frame_fifo_ctrl
//
// Frame-level sequencer in front of the 96-bit receive FIFO (I_hs_rx_clk
// domain). Each frame start pulses the FIFO reset for RST_CYCLES cycles. It
// then blocks writes for GUARD_CYCLES cycles and then streams pixel words into
// the FIFO. In the stream phase it counts accepted words and records sticky
// short-frame, long-frame and overflow errors.
//
// Handshake: a word is offered when I_valid is high in a cycle. There is no
// back-pressure. A word that cannot be accepted is dropped. When a word is
// accepted, O_fifo_we/O_fifo_di show it exactly one cycle later.
//
// Ports
//   I_hs_rx_clk     receive clock, rising edge
//   I_rst_n         asynchronous active-low reset
//   I_frame_start   single-cycle frame start (restarts from any state)
//   I_frame_end     single-cycle frame end (only honoured in STREAM)
//   I_valid/I_data  input word (4 packed RGB888 pixels)
//   I_fifo_wrusedw  FIFO write-side fill level
//   I_err_clr       clears the sticky error flags (a same-cycle set wins)
//   O_fifo_rst      FIFO reset, high exactly while in RESET
//   O_fifo_we/di    registered FIFO write port
//   O_frame_active  high exactly while in STREAM
//   O_word_cnt      words accepted in the current/last frame
//   O_err_short/long/ovf  sticky error flags
// -----------------------------------------------------------------------------
module rx_frame_fifo_ctrl #(
   parameter int RST_CYCLES      = 11,
   parameter int GUARD_CYCLES    = 4,
   parameter int WORDS_PER_FRAME = 518400,
   parameter int CNT_W           = 20,
   parameter int USEDW_W         = 9,
   parameter int AFULL_LEVEL     = 500
) (
   input  logic               I_hs_rx_clk,
   input  logic               I_rst_n,
   input  logic               I_frame_start,
   input  logic               I_frame_end,
   input  logic               I_valid,
   input  logic [95:0]        I_data,
   input  logic [USEDW_W-1:0] I_fifo_wrusedw,
   input  logic               I_err_clr,
   output logic               O_fifo_rst,
   output logic               O_fifo_we,
   output logic [95:0]        O_fifo_di,
   output logic               O_frame_active,
   output logic [CNT_W-1:0]   O_word_cnt,
   output logic               O_err_short,
   output logic               O_err_long,
   output logic               O_err_ovf
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_RESET  = 3'd1,
      S_GUARD  = 3'd2,
      S_STREAM = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   localparam logic [CNT_W-1:0]   WPF       = CNT_W'(WORDS_PER_FRAME);
   localparam logic [USEDW_W-1:0] AFULL     = USEDW_W'(AFULL_LEVEL);
   localparam logic [15:0]        RST_LAST  = 16'(RST_CYCLES - 1);
   localparam logic [15:0]        GRD_LAST  = 16'(GUARD_CYCLES - 1);

   state_t             state_q, state_d;
   logic [15:0]        phase_q, phase_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               rst_q, rst_d;
   logic               we_q, we_d;
   logic [95:0]        di_q, di_d;
   logic               active_q, active_d;
   logic               short_q, short_d;
   logic               long_q, long_d;
   logic               ovf_q, ovf_d;

   // A word is only considered in STREAM. A same-cycle frame start wins and
   // drops the word silently.
   logic             word_ok;
   logic             below_afull;
   logic             room;
   logic             accept;
   logic             end_short;
   logic [CNT_W-1:0] cnt_inc;

   assign word_ok     = (state_q == S_STREAM) && I_valid && !I_frame_start;
   assign below_afull = (I_fifo_wrusedw < AFULL);
   assign room        = (cnt_q < WPF);
   assign accept      = word_ok && below_afull && room;
   assign cnt_inc     = cnt_q + CNT_W'(1);
   // The length check includes a word accepted in the I_frame_end cycle.
   assign end_short   = (state_q == S_STREAM) && I_frame_end &&
                        ((accept ? cnt_inc : cnt_q) < WPF);

   // State and registered outputs
   always_ff @(posedge I_hs_rx_clk or negedge I_rst_n) begin
      if (!I_rst_n) begin
         state_q  <= S_IDLE;
         phase_q  <= '0;
         cnt_q    <= '0;
         rst_q    <= 1'b0;
         we_q     <= 1'b0;
         di_q     <= '0;
         active_q <= 1'b0;
         short_q  <= 1'b0;
         long_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         phase_q  <= phase_d;
         cnt_q    <= cnt_d;
         rst_q    <= rst_d;
         we_q     <= we_d;
         di_q     <= di_d;
         active_q <= active_d;
         short_q  <= short_d;
         long_q   <= long_d;
         ovf_q    <= ovf_d;
      end
   end

   // Next state. The phase counter is shared by RESET and GUARD.
   always_comb begin
      state_d = state_q;
      phase_d = phase_q + 16'd1;
      if (I_frame_start) begin
         state_d = S_RESET;
         phase_d = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               phase_d = '0;
            end
            S_RESET: begin
               if (phase_q == RST_LAST) begin
                  phase_d = '0;
                  state_d = (GUARD_CYCLES == 0) ? S_STREAM : S_GUARD;
               end
            end
            S_GUARD: begin
               if (phase_q == GRD_LAST) begin
                  phase_d = '0;
                  state_d = S_STREAM;
               end
            end
            S_STREAM: begin
               phase_d = '0;
               if (I_frame_end) state_d = S_DONE;
            end
            S_DONE: begin
               phase_d = '0;
               state_d = S_IDLE;
            end
            default: begin
               phase_d = '0;
               state_d = S_IDLE;
            end
         endcase
      end
   end

   // Output next values. They are registered, so reset/active follow state_d.
   always_comb begin
      rst_d    = (state_d == S_RESET);
      active_d = (state_d == S_STREAM);
      we_d     = accept;
      di_d     = accept ? I_data : di_q;
      cnt_d    = cnt_q;
      if (I_frame_start)
         cnt_d = '0;
      else if (accept)
         cnt_d = cnt_inc;
      short_d  = end_short || (short_q && !I_err_clr);
      long_d   = (word_ok && !room) || (long_q && !I_err_clr);
      ovf_d    = (word_ok && !below_afull) || (ovf_q && !I_err_clr);
   end

   assign O_fifo_rst     = rst_q;
   assign O_fifo_we      = we_q;
   assign O_fifo_di      = di_q;
   assign O_frame_active = active_q;
   assign O_word_cnt     = cnt_q;
   assign O_err_short    = short_q;
   assign O_err_long     = long_q;
   assign O_err_ovf      = ovf_q;

endmodule

// File: tb/tb_rx_frame_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// Directed bench for rx_frame_fifo_ctrl with WORDS_PER_FRAME=8,
// RST_CYCLES=3 and GUARD_CYCLES=2. The inputs change 1 ns after a rising edge.
// The registered outputs are checked at that same point, so each check covers
// the edge that just happened.
// -----------------------------------------------------------------------------
module tb_rx_frame_fifo_ctrl;

   localparam int CNT_W   = 20;
   localparam int USEDW_W = 9;

   logic               clk;
   logic               rst_n;
   logic               frame_start;
   logic               frame_end;
   logic               valid;
   logic [95:0]        data;
   logic [USEDW_W-1:0] usedw;
   logic               err_clr;
   logic               fifo_rst;
   logic               fifo_we;
   logic [95:0]        fifo_di;
   logic               frame_active;
   logic [CNT_W-1:0]   word_cnt;
   logic               err_short;
   logic               err_long;
   logic               err_ovf;

   int n_checks = 0;
   int n_errors = 0;

   rx_frame_fifo_ctrl #(
      .RST_CYCLES      (3),
      .GUARD_CYCLES    (2),
      .WORDS_PER_FRAME (8),
      .CNT_W           (CNT_W),
      .USEDW_W         (USEDW_W),
      .AFULL_LEVEL     (500)
   ) dut (
      .I_hs_rx_clk    (clk),
      .I_rst_n        (rst_n),
      .I_frame_start  (frame_start),
      .I_frame_end    (frame_end),
      .I_valid        (valid),
      .I_data         (data),
      .I_fifo_wrusedw (usedw),
      .I_err_clr      (err_clr),
      .O_fifo_rst     (fifo_rst),
      .O_fifo_we      (fifo_we),
      .O_fifo_di      (fifo_di),
      .O_frame_active (frame_active),
      .O_word_cnt     (word_cnt),
      .O_err_short    (err_short),
      .O_err_long     (err_long),
      .O_err_ovf      (err_ovf)
   );

   // Clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not reach the end");
      $fatal(1, "timeout");
   end

   // Helpers
   function automatic logic [95:0] word(input int k);
      return {32'hDEAD_0000 + 32'(k), 32'hBEEF_0000 + 32'(k), 32'h1234_0000 + 32'(k)};
   endfunction

   task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_flags(input string tag, input logic s, input logic l, input logic o);
      chk({tag, "_short"}, 96'(err_short), 96'(s));
      chk({tag, "_long"},  96'(err_long),  96'(l));
      chk({tag, "_ovf"},   96'(err_ovf),   96'(o));
   endtask

   // Frame start followed by the 3-cycle reset and the 2-cycle guard. The
   // task ends with the block in STREAM. The clr input pulses I_err_clr with
   // the start. The v input offers a word in the start cycle, and that word
   // must be dropped.
   task automatic start_frame(input string tag, input logic clr, input logic v);
      frame_start = 1'b1;
      err_clr     = clr;
      valid       = v;
      data        = word(77);
      tick();
      frame_start = 1'b0;
      err_clr     = 1'b0;
      valid       = 1'b0;
      chk({tag, "_rst0"},  96'(fifo_rst),     96'(1));
      chk({tag, "_cnt0"},  96'(word_cnt),     96'(0));
      chk({tag, "_we0"},   96'(fifo_we),      96'(0));
      chk({tag, "_act0"},  96'(frame_active), 96'(0));
      tick();
      chk({tag, "_rst1"},  96'(fifo_rst),     96'(1));
      tick();
      chk({tag, "_rst2"},  96'(fifo_rst),     96'(1));
      tick();
      chk({tag, "_rst3"},  96'(fifo_rst),     96'(0));
      tick();
      chk({tag, "_act4"},  96'(frame_active), 96'(0));
      tick();
      chk({tag, "_act5"},  96'(frame_active), 96'(1));
   endtask

   // Driver for one valid word
   task automatic send_word(input string tag, input int k, input logic [USEDW_W-1:0] lvl,
                            input logic exp_we, input int exp_cnt, input int exp_di_k);
      valid = 1'b1;
      data  = word(k);
      usedw = lvl;
      tick();
      valid = 1'b0;
      usedw = '0;
      chk({tag, "_we"},  96'(fifo_we),  96'(exp_we));
      chk({tag, "_cnt"}, 96'(word_cnt), 96'(exp_cnt));
      chk({tag, "_di"},  fifo_di,       word(exp_di_k));
   endtask

   task automatic end_frame();
      frame_end = 1'b1;
      tick();
      frame_end = 1'b0;
   endtask

   initial begin
      rst_n       = 1'b0;
      frame_start = 1'b0;
      frame_end   = 1'b0;
      valid       = 1'b0;
      data        = '0;
      usedw       = '0;
      err_clr     = 1'b0;
      #12;
      chk("reset_rst",    96'(fifo_rst),     96'(0));
      chk("reset_we",     96'(fifo_we),      96'(0));
      chk("reset_di",     fifo_di,           96'(0));
      chk("reset_active", 96'(frame_active), 96'(0));
      chk("reset_cnt",    96'(word_cnt),     96'(0));
      chk_flags("reset", 1'b0, 1'b0, 1'b0);
      rst_n = 1'b1;
      tick();

      // Nominal frame: 8 words, no errors
      start_frame("nom", 1'b0, 1'b0);
      for (int k = 1; k <= 8; k++)
         send_word("nom_w", k, 9'd0, 1'b1, k, k);
      end_frame();
      chk("nom_end_cnt", 96'(word_cnt),     96'(8));
      chk("nom_end_act", 96'(frame_active), 96'(0));
      chk_flags("nom_end", 1'b0, 1'b0, 1'b0);
      tick();
      // A frame end in IDLE is ignored.
      end_frame();
      chk_flags("idle_end", 1'b0, 1'b0, 1'b0);
      chk("idle_end_cnt", 96'(word_cnt), 96'(8));

      // Guard drop: valid is held high from the start. No write happens until STREAM.
      valid       = 1'b1;
      data        = word(50);
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      chk("grd_we0", 96'(fifo_we), 96'(0));
      for (int c = 1; c <= 5; c++) begin
         tick();
         chk("grd_we_blk", 96'(fifo_we), 96'(0));
      end
      chk("grd_act", 96'(frame_active), 96'(1));
      tick();
      chk("grd_first_we",  96'(fifo_we),  96'(1));
      chk("grd_first_di",  fifo_di,       word(50));
      chk("grd_first_cnt", 96'(word_cnt), 96'(1));
      valid = 1'b0;
      end_frame();
      chk_flags("grd_end", 1'b1, 1'b0, 1'b0);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      chk_flags("grd_clr", 1'b0, 1'b0, 1'b0);

      // Short frame: 6 words
      start_frame("sht", 1'b0, 1'b0);
      for (int k = 1; k <= 6; k++)
         send_word("sht_w", 10 + k, 9'd0, 1'b1, k, 10 + k);
      end_frame();
      chk("sht_cnt", 96'(word_cnt), 96'(6));
      chk_flags("sht_end", 1'b1, 1'b0, 1'b0);
      tick();

      // Long frame: 10 words offered, 8 written. Flags are cleared at the start.
      start_frame("lng", 1'b1, 1'b0);
      chk_flags("lng_start", 1'b0, 1'b0, 1'b0);
      for (int k = 1; k <= 8; k++)
         send_word("lng_w", 20 + k, 9'd0, 1'b1, k, 20 + k);
      send_word("lng_w9", 29, 9'd0, 1'b0, 8, 28);
      chk("lng_flag9", 96'(err_long), 96'(1));
      send_word("lng_w10", 30, 9'd0, 1'b0, 8, 28);
      end_frame();
      chk("lng_cnt", 96'(word_cnt), 96'(8));
      chk_flags("lng_end", 1'b0, 1'b1, 1'b0);
      tick();

      // Overflow: words 3-4 are offered at wrusedw=500. Word 2 is offered at 499.
      start_frame("ovf", 1'b1, 1'b0);
      chk_flags("ovf_start", 1'b0, 1'b0, 1'b0);
      send_word("ovf_w1", 41, 9'd0,   1'b1, 1, 41);
      send_word("ovf_w2", 42, 9'd499, 1'b1, 2, 42);
      send_word("ovf_w3", 43, 9'd500, 1'b0, 2, 42);
      chk("ovf_flag3", 96'(err_ovf), 96'(1));
      err_clr = 1'b1;   // The clear loses to a set in the same cycle.
      send_word("ovf_w4", 44, 9'd500, 1'b0, 2, 42);
      err_clr = 1'b0;
      chk("ovf_flag4", 96'(err_ovf), 96'(1));
      for (int k = 5; k <= 8; k++)
         send_word("ovf_w", 40 + k, 9'd10, 1'b1, k - 2, 40 + k);
      end_frame();
      chk("ovf_cnt", 96'(word_cnt), 96'(6));
      chk_flags("ovf_end", 1'b1, 1'b0, 1'b1);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      chk_flags("ovf_clr", 1'b0, 1'b0, 1'b0);

      // Restart mid-STREAM after 4 words. The word in the start cycle is dropped.
      start_frame("rs1", 1'b0, 1'b0);
      for (int k = 1; k <= 4; k++)
         send_word("rs1_w", 60 + k, 9'd0, 1'b1, k, 60 + k);
      start_frame("rs2", 1'b0, 1'b1);
      chk_flags("rs2", 1'b0, 1'b0, 1'b0);
      for (int k = 1; k <= 5; k++)
         send_word("rs2_w", 80 + k, 9'd0, 1'b1, k, 80 + k);
      // Start and end arrive together at cnt=5.
      frame_start = 1'b1;
      frame_end   = 1'b1;
      tick();
      frame_start = 1'b0;
      frame_end   = 1'b0;
      chk("se_short", 96'(err_short),    96'(1));
      chk("se_rst",   96'(fifo_rst),     96'(1));
      chk("se_act",   96'(frame_active), 96'(0));
      chk("se_cnt",   96'(word_cnt),     96'(0));
      tick();
      chk("se_rst1", 96'(fifo_rst), 96'(1));
      // A start inside RESET triggers a full 3-cycle pulse again.
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      chk("rt_rst0", 96'(fifo_rst), 96'(1));
      tick();
      chk("rt_rst1", 96'(fifo_rst), 96'(1));
      tick();
      chk("rt_rst2", 96'(fifo_rst), 96'(1));
      tick();
      chk("rt_rst3", 96'(fifo_rst), 96'(0));
      tick();
      tick();
      chk("rt_act", 96'(frame_active), 96'(1));

      // Asynchronous reset mid-STREAM
      send_word("ar_w1", 91, 9'd0, 1'b1, 1, 91);
      send_word("ar_w2", 92, 9'd0, 1'b1, 2, 92);
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar_rst",    96'(fifo_rst),     96'(0));
      chk("ar_we",     96'(fifo_we),      96'(0));
      chk("ar_di",     fifo_di,           96'(0));
      chk("ar_active", 96'(frame_active), 96'(0));
      chk("ar_cnt",    96'(word_cnt),     96'(0));
      chk_flags("ar", 1'b0, 1'b0, 1'b0);
      #2;
      rst_n = 1'b1;
      end_frame();
      chk("ar_end_act", 96'(frame_active), 96'(0));
      chk_flags("ar_end", 1'b0, 1'b0, 1'b0);
      valid = 1'b1;
      data  = word(99);
      tick();
      valid = 1'b0;
      chk("ar_idle_we",  96'(fifo_we),  96'(0));
      chk("ar_idle_cnt", 96'(word_cnt), 96'(0));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
